// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional fair arbitration is selected with the MEM_ARB_FAIR_EN macro.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_RD_WAIT
    } arb_state_t;

    typedef enum logic {
        PORT_IF,
        PORT_LS
    } arb_port_t;

    localparam int MEM_LAT_MAX = 4;
    // Counter holds remaining wait cycles (MEM_LAT-1 at most).
    localparam int CNT_W = $clog2(MEM_LAT_MAX);

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of mem_port_arbiter, grouped as one bus.
// slave = arbiter view, master = requesters + memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_rvalid, ls_gnt, ls_rvalid, rdata,
               mem_raddr, mem_waddr, mem_wdata, mem_wr, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_rvalid, ls_gnt, ls_rvalid, rdata,
               mem_raddr, mem_waddr, mem_wdata, mem_wr, busy
    );

endinterface

// File: rtl/arb_pick2.sv
// Combinational winner selection between fetch and load/store requests.
// MEM_ARB_FAIR_EN: round-robin on contested cycles, else load/store wins.
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic      if_req_i,
    input  logic      ls_req_i,
`ifdef MEM_ARB_FAIR_EN
    input  arb_port_t last_win_i,
`endif
    output logic      any_o,
    output arb_port_t win_o
);

    always_comb begin
        any_o = if_req_i | ls_req_i;
        win_o = ls_req_i ? PORT_LS : PORT_IF;
`ifdef MEM_ARB_FAIR_EN
        if (if_req_i && ls_req_i) begin
            win_o = (last_win_i == PORT_LS) ? PORT_IF : PORT_LS;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// tracking read latency and routing rvalid to the owner (MEM_ARB_FAIR_EN optional).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    mem_port_arbiter_if.slave bus
);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    arb_port_t         owner_q, owner_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              any_req;
    arb_port_t         win;
    logic              rd_done;
    logic              can_grant;
    logic              grant;
    logic              rd_grant;
    logic              wr_grant;
    logic [ADDR_W-1:0] gnt_addr;

`ifdef MEM_ARB_FAIR_EN
    arb_port_t last_q, last_d;
`endif

    arb_pick2 u_pick (
        .if_req_i   (bus.if_req),
        .ls_req_i   (bus.ls_req),
`ifdef MEM_ARB_FAIR_EN
        .last_win_i (last_q),
`endif
        .any_o      (any_req),
        .win_o      (win)
    );

    // The rvalid cycle also frees the port, so a grant can overlap it.
    assign rd_done   = (state_q == ARB_RD_WAIT) && (cnt_q == '0);
    assign can_grant = rst_n && ((state_q == ARB_IDLE) || rd_done);
    assign grant     = can_grant && any_req;
    assign gnt_addr  = (win == PORT_LS) ? bus.ls_addr : bus.if_addr;
    assign wr_grant  = grant && (win == PORT_LS) && bus.ls_we;
    assign rd_grant  = grant && !wr_grant;

    assign bus.if_gnt    = grant && (win == PORT_IF);
    assign bus.ls_gnt    = grant && (win == PORT_LS);
    assign bus.if_rvalid = rst_n && rd_done && (owner_q == PORT_IF);
    assign bus.ls_rvalid = rst_n && rd_done && (owner_q == PORT_LS);
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_raddr = rd_grant ? gnt_addr : raddr_q;
    assign bus.mem_waddr = wr_grant ? bus.ls_addr : waddr_q;
    assign bus.mem_wdata = wr_grant ? bus.ls_wdata : wdata_q;
    assign bus.mem_wr    = wr_grant;
    assign bus.busy      = (state_q == ARB_RD_WAIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            ARB_IDLE: ;
            ARB_RD_WAIT: begin
                if (cnt_q == '0) state_d = ARB_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ARB_IDLE;
        endcase
        if (rd_grant) begin
            state_d = ARB_RD_WAIT;
            cnt_d   = CNT_W'(MEM_LAT - 1);
            owner_d = win;
            raddr_d = gnt_addr;
        end
        if (wr_grant) begin
            waddr_d = bus.ls_addr;
            wdata_d = bus.ls_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            owner_q <= PORT_IF;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef MEM_ARB_FAIR_EN
    assign last_d = grant ? win : last_q;

    always_ff @(posedge clk) begin
        if (!rst_n) last_q <= PORT_IF;
        else        last_q <= last_d;
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with MEM_LAT 1, 2, 3
// and a registered-read memory model behind the LAT1/LAT3 instances.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: word (i) resets to A000_0000|i, one-cycle registered read.
    logic [31:0] m1 [0:63];
    logic [31:0] m3 [0:63];
    logic [31:0] rd1, rd3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) m1[i] <= 32'hA000_0000 | 32'(i);
        end else if (b1.mem_wr) begin
            m1[b1.mem_waddr[7:2]] <= b1.mem_wdata;
        end
        rd1 <= m1[b1.mem_raddr[7:2]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) m3[i] <= 32'hA000_0000 | 32'(i);
        end else if (b3.mem_wr) begin
            m3[b3.mem_waddr[7:2]] <= b3.mem_wdata;
        end
        rd3 <= m3[b3.mem_raddr[7:2]];
    end

    assign b1.mem_rdata = rd1;
    assign b2.mem_rdata = 32'h0;
    assign b3.mem_rdata = rd3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    logic [5:0] exp_ls, exp_if;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        b1.if_req = 0; b1.if_addr = '0; b1.ls_req = 0; b1.ls_we = 0; b1.ls_addr = '0; b1.ls_wdata = '0;
        b2.if_req = 0; b2.if_addr = '0; b2.ls_req = 0; b2.ls_we = 0; b2.ls_addr = '0; b2.ls_wdata = '0;
        b3.if_req = 0; b3.if_addr = '0; b3.ls_req = 0; b3.ls_we = 0; b3.ls_addr = '0; b3.ls_wdata = '0;
`ifdef MEM_ARB_FAIR_EN
        exp_ls = 6'b010001;
        exp_if = 6'b000100;
`else
        exp_ls = 6'b010101;
        exp_if = 6'b000000;
`endif

        // Reset with a pending fetch request: grant must stay low.
        tick(); tick();
        b1.if_req = 1; b1.if_addr = 32'h10;
        tick();
        sample();
        chk("rst_if_gnt", 32'(b1.if_gnt), 32'd0);
        chk("rst_busy", 32'(b1.busy), 32'd0);
        chk("rst_raddr", b1.mem_raddr, 32'h0);
        chk("rst_mem_wr", 32'(b1.mem_wr), 32'd0);
        chk("rst_waddr", b1.mem_waddr, 32'h0);

        // Fetch at 0x10, MEM_LAT=1.
        tick(); rst_n = 1'b1;
        sample();
        chk("f_if_gnt", 32'(b1.if_gnt), 32'd1);
        chk("f_raddr", b1.mem_raddr, 32'h10);
        chk("f_ls_gnt", 32'(b1.ls_gnt), 32'd0);
        tick(); b1.if_req = 0;
        sample();
        chk("f_if_rvalid", 32'(b1.if_rvalid), 32'd1);
        chk("f_busy", 32'(b1.busy), 32'd1);
        chk("f_rdata", b1.rdata, 32'hA000_0004);
        chk("f_ls_rvalid", 32'(b1.ls_rvalid), 32'd0);

        // Store 0xDEADBEEF to 0x40.
        tick(); b1.ls_req = 1; b1.ls_we = 1; b1.ls_addr = 32'h40; b1.ls_wdata = 32'hDEAD_BEEF;
        sample();
        chk("st_ls_gnt", 32'(b1.ls_gnt), 32'd1);
        chk("st_mem_wr", 32'(b1.mem_wr), 32'd1);
        chk("st_waddr", b1.mem_waddr, 32'h40);
        chk("st_wdata", b1.mem_wdata, 32'hDEAD_BEEF);
        chk("st_busy", 32'(b1.busy), 32'd0);
        tick(); b1.ls_req = 0; b1.ls_we = 0; b1.ls_wdata = 32'h0;
        sample();
        chk("st_wr_off", 32'(b1.mem_wr), 32'd0);
        chk("st_waddr_hold", b1.mem_waddr, 32'h40);
        chk("st_wdata_hold", b1.mem_wdata, 32'hDEAD_BEEF);
        chk("st_no_rvalid", 32'(b1.ls_rvalid), 32'd0);

        // Load 0x40 back.
        tick(); b1.ls_req = 1; b1.ls_we = 0; b1.ls_addr = 32'h40;
        sample();
        chk("ld_ls_gnt", 32'(b1.ls_gnt), 32'd1);
        chk("ld_raddr", b1.mem_raddr, 32'h40);
        chk("ld_mem_wr", 32'(b1.mem_wr), 32'd0);
        tick(); b1.ls_req = 0;
        sample();
        chk("ld_ls_rvalid", 32'(b1.ls_rvalid), 32'd1);
        chk("ld_if_rvalid", 32'(b1.if_rvalid), 32'd0);
        chk("ld_rdata", b1.rdata, 32'hDEAD_BEEF);
        chk("ld_raddr_hold", b1.mem_raddr, 32'h40);

        // Contention on the MEM_LAT=2 instance, both held for six cycles.
        tick();
        b2.if_req = 1; b2.if_addr = 32'h08;
        b2.ls_req = 1; b2.ls_we = 0; b2.ls_addr = 32'h0C;
        for (int i = 0; i < 6; i++) begin
            sample();
            chk($sformatf("cont_ls_gnt_c%0d", i), 32'(b2.ls_gnt), 32'(exp_ls[i]));
            chk($sformatf("cont_if_gnt_c%0d", i), 32'(b2.if_gnt), 32'(exp_if[i]));
            if (i == 2) chk("cont_ls_rvalid_c2", 32'(b2.ls_rvalid), 32'd1);
            tick();
        end
        b2.if_req = 0; b2.ls_req = 0;

        // Load on MEM_LAT=3, store queued behind it.
        b3.ls_req = 1; b3.ls_we = 0; b3.ls_addr = 32'h44;
        sample();
        chk("l3_ls_gnt_t0", 32'(b3.ls_gnt), 32'd1);
        tick(); b3.ls_we = 1; b3.ls_addr = 32'h48; b3.ls_wdata = 32'h1234_5678;
        sample();
        chk("l3_ls_gnt_t1", 32'(b3.ls_gnt), 32'd0);
        chk("l3_busy_t1", 32'(b3.busy), 32'd1);
        chk("l3_wr_t1", 32'(b3.mem_wr), 32'd0);
        tick();
        sample();
        chk("l3_ls_gnt_t2", 32'(b3.ls_gnt), 32'd0);
        chk("l3_rvalid_t2", 32'(b3.ls_rvalid), 32'd0);
        tick();
        sample();
        chk("l3_ls_gnt_t3", 32'(b3.ls_gnt), 32'd1);
        chk("l3_rvalid_t3", 32'(b3.ls_rvalid), 32'd1);
        chk("l3_wr_t3", 32'(b3.mem_wr), 32'd1);
        chk("l3_rdata_t3", b3.rdata, 32'hA000_0011);
        tick(); b3.ls_req = 0; b3.ls_we = 0;
        sample();
        chk("l3_busy_t4", 32'(b3.busy), 32'd0);
        chk("l3_wr_t4", 32'(b3.mem_wr), 32'd0);
        chk("l3_waddr_t4", b3.mem_waddr, 32'h48);

        // Reset one cycle after a fetch grant on MEM_LAT=3.
        tick(); b3.if_req = 1; b3.if_addr = 32'h20;
        sample();
        chk("rr_if_gnt", 32'(b3.if_gnt), 32'd1);
        tick(); b3.if_req = 0; rst_n = 1'b0;
        sample();
        chk("rr_if_rvalid_rst", 32'(b3.if_rvalid), 32'd0);
        chk("rr_if_gnt_rst", 32'(b3.if_gnt), 32'd0);
        tick(); rst_n = 1'b1; b3.if_req = 1; b3.if_addr = 32'h24;
        sample();
        chk("rr_if_gnt_after", 32'(b3.if_gnt), 32'd1);
        chk("rr_raddr_after", b3.mem_raddr, 32'h24);
        chk("rr_busy_after", 32'(b3.busy), 32'd0);
        chk("rr_rvalid_after", 32'(b3.if_rvalid), 32'd0);
        chk("rr_waddr_after", b3.mem_waddr, 32'h0);
        chk("rr_wdata_after", b3.mem_wdata, 32'h0);
        chk("rr_wr_after", 32'(b3.mem_wr), 32'd0);
        tick(); b3.if_req = 0;
        sample();
        chk("rr_no_rvalid_t3", 32'(b3.if_rvalid), 32'd0);
        chk("rr_busy_t3", 32'(b3.busy), 32'd1);
        tick();
        sample();
        chk("rr_no_rvalid_t4", 32'(b3.if_rvalid), 32'd0);
        tick();
        sample();
        chk("rr_new_rvalid", 32'(b3.if_rvalid), 32'd1);
        chk("rr_new_rdata", b3.rdata, 32'hA000_0009);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
